// File: rtl/lcd_fb_pkg.sv
// Shared types and constants for the LCD framebuffer fetch block.
// Pixels are RGB565; two pixels are packed per 32-bit BRAM word.
package lcd_fb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LAST,
    FLUSH
  } state_t;

  localparam int PIX_W        = 16;
  localparam int PIX_PER_WORD = 2;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;

endpackage

// File: rtl/lcd_fb_fetch_if.sv
// BRAM port-2 read bus and RGB565 pixel stream.
// The master is the fetch block; the slave is BRAM plus LCD sink.
interface lcd_fb_fetch_if;
  import lcd_fb_pkg::*;

  logic [31:0]       port2addr;
  logic              port2cs;
  logic              port2we;
  logic [3:0]        port2bwe;
  logic [WORD_W-1:0] port2di;
  logic [WORD_W-1:0] port2do;
  logic [PIX_W-1:0]  pix_data;
  logic              pix_valid;
  logic              pix_ready;

  modport master (
    output port2addr, port2cs, port2we,
    output port2bwe, port2di,
    output pix_data, pix_valid,
    input  port2do, pix_ready
  );

  modport slave (
    input  port2addr, port2cs, port2we,
    input  port2bwe, port2di,
    input  pix_data, pix_valid,
    output port2do, pix_ready
  );

endinterface

// File: rtl/lcd_fb_fifo.sv
// Synchronous word FIFO with occupancy count and flush.
// Flush wins over push and pop in the same cycle.
module lcd_fb_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             empty
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_cnt == '0);
  assign w_pop  = pop && !empty;
  assign w_push = push && ((r_cnt != FULL) || w_pop);
  assign dout   = r_mem[r_rp];
  assign count  = r_cnt;

  always_ff @(posedge clk) begin
    if (w_push && !flush)
      r_mem[r_wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push)
        r_wp <= r_wp + 1'b1;
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/lcd_fb_fetch.sv
// Walks a framebuffer over BRAM port 2 and streams RGB565 pixels.
// Reads are credit-limited so a returning word always has a FIFO slot.
module lcd_fb_fetch
  import lcd_fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              enable,
  input  logic              BIGEND,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] frame_words,
  output logic              busy,
  output logic              frame_done,
  output logic              underflow,
  lcd_fb_fetch_if.master    bus
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_left;
  logic              r_rd_pend;
  logic              r_ptr;
  logic              r_zero_done;
  logic              r_underflow;

  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic [WORD_W-1:0] w_head;
  logic              w_credit;
  logic              w_cs;
  logic              w_push;
  logic              w_pop;
  logic              w_beat;
  logic              w_flush;
  logic              w_start;
  logic              w_last_push;

  assign w_credit = ({1'b0, w_count}
                    + {{CW{1'b0}}, r_rd_pend}) < DEPTH_C;
  assign w_cs     = (r_state == FETCH) && enable && w_credit;
  assign w_flush  = (r_state == FLUSH);
  assign w_push   = r_rd_pend && !w_flush;
  assign w_beat   = !w_empty && bus.pix_ready;
  assign w_pop    = w_beat && r_ptr;
  assign w_start  = (r_state == IDLE) && frame_start
                    && enable && (frame_words != '0);
  assign w_last_push = (r_state == LAST) && enable && r_rd_pend;

  lcd_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .flush (w_flush),
    .push  (w_push),
    .din   (bus.port2do),
    .pop   (w_pop),
    .dout  (w_head),
    .count (w_count),
    .empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_start) w_next = FETCH;
      FETCH:
        if (!enable)
          w_next = FLUSH;
        else if (w_cs && r_left == ADDR_W'(1))
          w_next = LAST;
      LAST:
        if (!enable)         w_next = FLUSH;
        else if (r_rd_pend)  w_next = IDLE;
      FLUSH:
        if (!r_rd_pend) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_left      <= '0;
      r_rd_pend   <= 1'b0;
      r_ptr       <= 1'b0;
      r_zero_done <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_rd_pend <= w_cs;
      if (w_start) begin
        r_addr <= base_addr;
        r_left <= frame_words;
      end else if (w_cs) begin
        r_addr <= r_addr + 1'b1;
        r_left <= r_left - 1'b1;
      end
      if (w_flush)
        r_ptr <= 1'b0;
      else if (w_beat)
        r_ptr <= ~r_ptr;
      r_zero_done <= (r_state == IDLE) && frame_start
                     && (frame_words == '0);
      if (w_start)
        r_underflow <= 1'b0;
      else if (busy && bus.pix_ready && w_empty)
        r_underflow <= 1'b1;
    end
  end

  assign busy       = (r_state != IDLE);
  assign frame_done = w_last_push || r_zero_done;
  assign underflow  = r_underflow;

  assign bus.port2addr = {{(32-ADDR_W){1'b0}}, r_addr};
  assign bus.port2cs   = w_cs;
  assign bus.port2we   = 1'b0;
  assign bus.port2bwe  = 4'b0000;
  assign bus.port2di   = '0;
  assign bus.pix_valid = !w_empty;
  assign bus.pix_data  = (r_ptr ^ BIGEND) ? w_head[31:16]
                                          : w_head[15:0];

endmodule

// File: tb/tb_lcd_fb_fetch.sv
// Scoreboard bench for lcd_fb_fetch: expected reads and pixels are
// queued at stimulus time and checked by a negedge monitor.
module tb_lcd_fb_fetch;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        enable;
  logic        BIGEND;
  logic        frame_start;
  logic [15:0] base_addr;
  logic [15:0] frame_words;
  logic        busy;
  logic        frame_done;
  logic        underflow;

  lcd_fb_fetch_if bus();

  lcd_fb_fetch #(
    .FIFO_DEPTH (16),
    .ADDR_W     (16)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .enable      (enable),
    .BIGEND      (BIGEND),
    .frame_start (frame_start),
    .base_addr   (base_addr),
    .frame_words (frame_words),
    .busy        (busy),
    .frame_done  (frame_done),
    .underflow   (underflow),
    .bus         (bus.master)
  );

  always #5 HCLK = ~HCLK;

  int          n_checks = 0;
  int          n_errors = 0;
  int          done_cnt = 0;
  int          cs_cnt   = 0;
  logic [15:0] exp_pix[$];
  logic [31:0] exp_addr[$];
  logic [15:0] bram_base = 16'h0;
  bit          bigmode   = 1'b0;

  function automatic logic [31:0] word_of(input logic [15:0] a);
    logic [15:0] off;
    off = a - bram_base;
    if (bigmode) return 32'h12345678;
    return 32'hAAAA5555 + {16'h0, off};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge HCLK)
    if (bus.port2cs) bus.port2do <= word_of(bus.port2addr[15:0]);

  always @(negedge HCLK) begin
    if (!HRESET) begin
      if (bus.port2cs) begin
        cs_cnt++;
        if (exp_addr.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL addr: unexpected read at %h", bus.port2addr);
        end else
          chk("addr", bus.port2addr, exp_addr.pop_front());
      end
      if (bus.pix_valid && bus.pix_ready) begin
        if (exp_pix.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL pix: unexpected pixel %h", bus.pix_data);
        end else
          chk("pix", {16'h0, bus.pix_data}, {16'h0, exp_pix.pop_front()});
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic start(input logic [15:0] b, input logic [15:0] n,
                       input bit pp);
    for (int i = 0; i < int'(n); i++) begin
      logic [15:0] a;
      logic [31:0] w;
      a = b + 16'(i);
      exp_addr.push_back({16'h0, a});
      if (pp) begin
        w = word_of(a);
        exp_pix.push_back(w[15:0]);
        exp_pix.push_back(w[31:16]);
      end
    end
    @(posedge HCLK); #1;
    base_addr   = b;
    frame_words = n;
    frame_start = 1'b1;
    @(posedge HCLK); #1;
    frame_start = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((busy || exp_pix.size() != 0) && n < 3000) begin
      @(negedge HCLK);
      n++;
    end
    chk({nm, " queue"}, exp_pix.size(), 0);
    chk({nm, " busy"}, {31'h0, busy}, 0);
  endtask

  initial begin
    int d0;
    int c0;
    int n;
    HRESET = 1'b1;
    enable = 1'b0;
    BIGEND = 1'b0;
    frame_start = 1'b0;
    base_addr = '0;
    frame_words = '0;
    bus.pix_ready = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst busy", {31'h0, busy}, 0);
    chk("rst done", {31'h0, frame_done}, 0);
    chk("rst unf", {31'h0, underflow}, 0);
    chk("rst valid", {31'h0, bus.pix_valid}, 0);
    chk("rst cs", {31'h0, bus.port2cs}, 0);
    chk("rst we", {31'h0, bus.port2we}, 0);
    chk("rst bwe", {28'h0, bus.port2bwe}, 0);
    chk("rst di", bus.port2di, 0);
    enable = 1'b1;

    // basic frame
    bus.pix_ready = 1'b1;
    bram_base = 16'h0010;
    exp_pix.push_back(16'h5555); exp_pix.push_back(16'hAAAA);
    exp_pix.push_back(16'h5556); exp_pix.push_back(16'hAAAA);
    exp_pix.push_back(16'h5557); exp_pix.push_back(16'hAAAA);
    exp_pix.push_back(16'h5558); exp_pix.push_back(16'hAAAA);
    d0 = done_cnt;
    start(16'h0010, 16'd4, 1'b0);
    drain("basic");
    chk("basic done", done_cnt - d0, 1);
    chk("basic addrs", exp_addr.size(), 0);

    // zero-length frame
    d0 = done_cnt;
    start(16'h0000, 16'd0, 1'b0);
    repeat (2) @(negedge HCLK);
    chk("zero done", done_cnt - d0, 1);
    chk("zero busy", {31'h0, busy}, 0);

    // backpressure
    bus.pix_ready = 1'b0;
    bram_base = 16'h0100;
    c0 = cs_cnt;
    start(16'h0100, 16'd40, 1'b1);
    repeat (100) @(negedge HCLK);
    chk("bp reads", cs_cnt - c0, 16);
    bus.pix_ready = 1'b1;
    drain("bp");
    chk("bp total", cs_cnt - c0, 40);

    // big-endian halfword order
    BIGEND = 1'b1;
    bigmode = 1'b1;
    exp_pix.push_back(16'h1234);
    exp_pix.push_back(16'h5678);
    start(16'h0200, 16'd1, 1'b0);
    drain("bigend");
    BIGEND = 1'b0;
    bigmode = 1'b0;

    // address wrap
    bram_base = 16'hFFFE;
    start(16'hFFFE, 16'd4, 1'b1);
    drain("wrap");

    // abort with a read in flight
    bus.pix_ready = 1'b0;
    bram_base = 16'h0040;
    start(16'h0040, 16'd40, 1'b0);
    repeat (3) @(negedge HCLK);
    n = 0;
    while (!bus.port2cs && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    chk("abort pre cs", {31'h0, bus.port2cs}, 1);
    d0 = done_cnt;
    @(posedge HCLK); #1;
    enable = 1'b0;
    #1 chk("abort cs", {31'h0, bus.port2cs}, 0);
    @(posedge HCLK);
    @(posedge HCLK); #1;
    chk("abort busy", {31'h0, busy}, 0);
    chk("abort valid", {31'h0, bus.pix_valid}, 0);
    exp_addr.delete();
    repeat (3) @(negedge HCLK);
    chk("abort done", done_cnt - d0, 0);
    enable = 1'b1;
    bus.pix_ready = 1'b1;
    bram_base = 16'h0020;
    start(16'h0020, 16'd2, 1'b1);
    drain("restart");

    // underflow is sticky
    bram_base = 16'h0050;
    start(16'h0050, 16'd8, 1'b1);
    drain("unf");
    chk("unf set", {31'h0, underflow}, 1);
    repeat (20) @(negedge HCLK);
    chk("unf hold", {31'h0, underflow}, 1);

    // mid-frame reset
    bus.pix_ready = 1'b0;
    bram_base = 16'h0060;
    start(16'h0060, 16'd40, 1'b0);
    chk("unf clr", {31'h0, underflow}, 0);
    repeat (30) @(negedge HCLK);
    chk("pre rst valid", {31'h0, bus.pix_valid}, 1);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    chk("mrst busy", {31'h0, busy}, 0);
    chk("mrst valid", {31'h0, bus.pix_valid}, 0);
    chk("mrst cs", {31'h0, bus.port2cs}, 0);
    chk("mrst done", {31'h0, frame_done}, 0);
    chk("mrst unf", {31'h0, underflow}, 0);
    exp_addr.delete();
    bus.pix_ready = 1'b1;
    bram_base = 16'h0030;
    start(16'h0030, 16'd1, 1'b1);
    drain("post rst");
    repeat (10) @(negedge HCLK);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: timeout, checks %0d errors %0d",
             n_checks, n_errors);
    $fatal(1);
  end

endmodule

// File: doc/lcd_fb_fetch.md
Name: lcd_fb_fetch

Overview:
- Downstream consumer of the framebuffer BRAM's second port: AHB masters write pixels via port 1; this block reads them back over port 2.
- Walks a frame linearly from a programmed base word address and unpacks each 32-bit word into two RGB565 pixels.
- Buffers pixels in a small FIFO and presents them to the LCD timing generator on a valid/ready stream.

Parameters:
- FIFO_DEPTH, 16, word-entry depth of the internal FIFO; power of two, minimum 4.
- ADDR_W, 16, word-address width driven onto port2addr[ADDR_W-1:0]; upper bits of port2addr are tied to 0.

Ports:
- HCLK  in  1  single clock; also clocks BRAM port 2.
- HRESET  in  1  synchronous, active-high reset.
- enable  in  1  level; deassert aborts the current frame.
- BIGEND  in  1  halfword order select.
- frame_start  in  1  one-cycle pulse; starts a frame fetch.
- base_addr  in  ADDR_W  first word address of the frame.
- frame_words  in  ADDR_W  words per frame; 0 means empty frame.
- port2addr  out  32  BRAM word address.
- port2cs  out  1  BRAM read strobe.
- port2we  out  1  always 0.
- port2bwe  out  4  always 4'b0000.
- port2di  out  32  always 0.
- port2do  in  32  BRAM read data, valid one cycle after port2cs.
- pix_data  out  16  RGB565 pixel.
- pix_valid  out  1  pixel available.
- pix_ready  in  1  sink accepts pixel.
- busy  out  1  high while the FSM is not IDLE.
- frame_done  out  1  one-cycle pulse when the last word of a frame is written into the FIFO.
- underflow  out  1  sticky error flag.

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, in-flight flag clear, halfword pointer 0.
- Read latency: port2do is captured and pushed into the FIFO on the cycle after port2cs=1. At most one read is in flight per cycle (rd_pend flag).
- Credit rule: issue a read only if fifo_count + rd_pend < FIFO_DEPTH, so a returning word is never dropped.
- FSM, IDLE:
  - frame_start & enable & frame_words!=0: load addr=base_addr, left=frame_words, go to FETCH.
  - frame_start with frame_words==0: pulse frame_done next cycle and stay in IDLE.
- FSM, FETCH:
  - Each cycle with credit, assert port2cs with port2addr=addr, then addr++ and left--.
  - addr wraps modulo 2^ADDR_W.
  - When the last read issues (left reaches 0), go to LAST.
- FSM, LAST: wait for rd_pend to clear; on the push of the final word, pulse frame_done and go to IDLE.
- Abort: enable=0 in FETCH or LAST moves the FSM to FLUSH.
  - FLUSH: no new reads; the in-flight word is discarded; FIFO is cleared; pointer reset.
  - FLUSH goes to IDLE once rd_pend=0. No frame_done on abort.
- Ignored starts: frame_start while busy=1 is ignored.
- Pixel output:
  - FIFO head word W. BIGEND=0 gives W[15:0] then W[31:16]; BIGEND=1 gives W[31:16] then W[15:0].
  - pix_valid = FIFO not empty.
  - A beat completes on pix_valid & pix_ready; the pointer toggles; the word is popped after its second halfword.
- Simultaneous push and pop in one cycle: count unchanged.
- Underflow: set when busy & pix_ready & !pix_valid. Cleared only by HRESET or by a frame_start that is accepted.
- Combinational paths: none from pix_ready to port2cs. pix_data and pix_valid come from registers and the FIFO head only.

Decomposition:
- Package lcd_fb_pkg:
  - FSM state enum {IDLE, FETCH, LAST, FLUSH}.
  - RGB565 pixel width constant (16).
  - Pixels-per-word constant (2).
- One sub-module: lcd_fb_fifo, a synchronous word FIFO with count output and a flush input.
- Fetch FSM and unpacker live in the top module.

Test Plan:
- Basic frame: base=0x0010, frame_words=4, BRAM model returns 0xAAAA5555+i, pix_ready=1, BIGEND=0.
  - Addresses 0x10..0x13 read.
  - Pixels 5555,AAAA,5556,AAAA,... (8 total).
  - One frame_done pulse; busy then drops.
- Backpressure: frame_words=40, pix_ready=0 for 100 cycles.
  - Exactly FIFO_DEPTH (16) reads are issued; then port2cs stays 0.
  - Release pix_ready: all 80 pixels arrive in order, none lost.
- BIGEND=1 with word 0x12345678: pixel order 1234 then 5678.
- Wrap: base=0xFFFE, frame_words=4 -> addresses FFFE, FFFF, 0000, 0001.
- Abort: deassert enable mid-FETCH with rd_pend=1.
  - port2cs stops the same cycle.
  - FIFO empties; FSM is IDLE within 2 cycles; no frame_done.
  - A later frame_start fetches correctly from base.
- Underflow and reset: pix_ready=1 while the FIFO is starved (BRAM stalled via credit) sets underflow, which stays set.
  - Mid-frame HRESET=1 for one cycle clears all outputs and the FIFO.
